spi_adc_responder: RTL and testbench
====================================

# spi_adc_responder

SPI responder that models the team's serial ADC from the converter side. It sits opposite `spi_wr_adc` and is clocked by `clk_i`. It decodes the 8-bit command that `spi_wr_adc` shifts out on MOSI, then returns a 12-bit sample on MISO, selected from eight channel inputs. It is used in simulation and on the FPGA loopback build, so the matrix-scan datapath can be exercised without the physical converter.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on each of `cs_i`, `dclk_i` and `mosi_i`. Legal values are 2 to 4.
- `clk_i`  in  1  system clock, 100 MHz.
- `rst_i`  in  1  asynchronous, active-low reset.
- `cs_i`  in  1  chip select, active-low. Asynchronous to `clk_i`.
- `dclk_i`  in  1  serial clock from the initiator. Asynchronous to `clk_i`.
- `mosi_i`  in  1  command bits from the initiator.
- `samples_i`  in  96  channel samples; channel n is `samples_i[12n+11:12n]`.
- `miso_o`  out  1  response bit to the initiator.
- `cmd_o`  out  8  last complete command received.
- `cmd_valid_o`  out  1  one-cycle pulse when `cmd_o` updates.
- `sample_o`  out  12  sample latched for the current frame.
- `eof_o`  out  1  one-cycle pulse: frame closed normally.
- `abort_o`  out  1  one-cycle pulse: frame closed early.

## Operation
- `cs_i`, `dclk_i` and `mosi_i` each pass through `SYNC_STAGES` flip-flops. Edges are detected on the synchronized copies; call them cs_s, dclk_s, mosi_s.
- The protocol is SPI mode 0:
  - the responder samples `mosi_s` on dclk_s rising edges;
  - the responder updates `miso_o` on dclk_s falling edges;
  - bits are sent MSB first.
- State machine:
  - IDLE: `miso_o`=0. A cs_s falling edge moves to WAIT_START.
  - WAIT_START: rising edges with `mosi_s`=0 are ignored. A rising edge with `mosi_s`=1 is the start bit: bit counter=1, shift register seeded with 1, go to CMD.
  - CMD: each rising edge shifts in one bit. On the 8th bit:
    - load `cmd_o`;
    - pulse `cmd_valid_o`;
    - latch `sample_o` from the channel given by cmd[6:4];
    - go to NULL.
  - NULL: the next falling edge drives `miso_o`=0 (null bit), data counter=11, go to DATA.
  - DATA: each falling edge drives `miso_o`=`sample_o`[data counter], then decrements the counter. After the edge that drives bit 0, go to TAIL.
  - TAIL: every further falling edge drives `miso_o`=0.
- A cs_s rising edge in any state returns to IDLE and forces `miso_o`=0.
  - If the edge occurs in TAIL, pulse `eof_o`.
  - If it occurs in CMD, NULL or DATA, pulse `abort_o`.
  - If it occurs in WAIT_START, pulse neither.
- Edges on dclk_s while cs_s=1 are ignored.
- `cmd[3:0]` (mode, SGL, PD) is stored in `cmd_o` but has no effect on the response.

## Timing
- Reset values: all outputs 0, state IDLE, synchronizers cleared to cs=1, dclk=0, mosi=0.
- Minimum `dclk_i` high time and low time: `SYNC_STAGES`+2 `clk_i` periods. Minimum gap between cs falling and the first dclk rise: the same. The codebase setting (60 clk per half period) has large margin.
- `miso_o` updates exactly 1 `clk_i` cycle after the falling edge is seen on dclk_s. That is `SYNC_STAGES`+1 cycles after the pin toggles, so it is stable well before the next rising edge.
- Bit numbering within a frame:
  - initiator rising edges 1–8 carry the command;
  - rising edge 9 samples the null bit;
  - rising edges 10–21 sample D11..D0.
- `cmd_valid_o` pulses on the cycle after the 8th rising edge is detected.
- `sample_o` is captured on that same cycle. `samples_i` changes after that cycle have no effect until the next frame.
- `eof_o`/`abort_o` pulse 1 cycle after the cs_s rising edge.
- If a cs_s rising edge and a dclk_s edge are detected in the same cycle, cs wins: the dclk edge is discarded.
- A cs_s falling edge while not in IDLE cannot occur, because cs must rise first. A new frame may begin on the cycle after IDLE is re-entered.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). No pulse is emitted.

## Test plan
- Normal frame, channel 1:
  - stimulus: channel 1 sample = 12'hABC, cmd 8'b10010111, dclk half period 60 clk, 24 dclk cycles;
  - required: `cmd_valid_o` pulses once with `cmd_o`=8'h97; `sample_o`=12'hABC; initiator reads 0xABC on rising edges 10–21; `eof_o` pulses once.
- Leading zeros: 3 zero bits, then 8'h97 → identical response to the normal frame; `cmd_o`=8'h97.
- Channel sweep: cmd[6:4]=0..7 with channel n sample = 12'h100+n → the initiator reads 12'h100+n each frame.
- Late sample change: `samples_i` changed 2 cycles after `cmd_valid_o` → the returned data is the old value.
- Abort: cs raised after rising edge 14 → `abort_o` pulses once, no `eof_o`, `miso_o`=0 next cycle; the next full frame is correct.
- Reset mid-DATA: `rst_i` low for 5 cycles during bit D6 → all outputs 0 at once, state IDLE; the following frame returns correct data.

Source files
------------

// File: rtl/spi_adc_responder.sv
// Converter-side model of the serial ADC: decodes the 8-bit command shifted in on
// MOSI and returns the selected channel's 12-bit sample on MISO (SPI mode 0).
module spi_adc_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cs_i,
    input  logic        dclk_i,
    input  logic        mosi_i,
    input  logic [95:0] samples_i,
    output logic        miso_o,
    output logic [7:0]  cmd_o,
    output logic        cmd_valid_o,
    output logic [11:0] sample_o,
    output logic        eof_o,
    output logic        abort_o,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_START = 3'd1,
        S_CMD        = 3'd2,
        S_NULL       = 3'd3,
        S_DATA       = 3'd4,
        S_TAIL       = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] dclk_sync_q, dclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   dclk_prev_q, dclk_prev_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             shift_q, shift_d;
    logic [3:0]             data_cnt_q, data_cnt_d;
    logic                   miso_q, miso_d;
    logic [7:0]             cmd_q, cmd_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [11:0]            sample_q, sample_d;
    logic                   eof_q, eof_d;
    logic                   abort_q, abort_d;

    logic        cs_s, dclk_s, mosi_s;
    logic        cs_rise, cs_fall, dclk_rise, dclk_fall;
    logic [11:0] sel_sample;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign dclk_s = dclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Serial-clock edges only count while the chip is selected.
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign dclk_rise = dclk_s & ~dclk_prev_q & ~cs_s;
    assign dclk_fall = ~dclk_s & dclk_prev_q & ~cs_s;

    // Channel select comes from cmd[6:4], i.e. bits [5:3] of the shift register
    // at the moment the 8th bit arrives.
    always_comb begin
        sel_sample = '0;
        for (int i = 0; i < 8; i++) begin
            if (shift_q[5:3] == i[2:0]) sel_sample = samples_i[i*12 +: 12];
        end
    end

    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_i};
        dclk_sync_d = {dclk_sync_q[SYNC_STAGES-2:0], dclk_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        cs_prev_d   = cs_s;
        dclk_prev_d = dclk_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_cnt_d  = data_cnt_q;
        miso_d      = miso_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        sample_d    = sample_q;
        eof_d       = 1'b0;
        abort_d     = 1'b0;

        if (cs_rise) begin
            state_d = S_IDLE;
            miso_d  = 1'b0;
            eof_d   = (state_q == S_TAIL);
            abort_d = (state_q == S_CMD) || (state_q == S_NULL) || (state_q == S_DATA);
        end else begin
            case (state_q)
                S_IDLE: begin
                    miso_d = 1'b0;
                    if (cs_fall) state_d = S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (dclk_rise && mosi_s) begin
                        bit_cnt_d = 3'd1;
                        shift_d   = 7'd1;
                        state_d   = S_CMD;
                    end
                end
                S_CMD: begin
                    if (dclk_rise) begin
                        shift_d   = {shift_q[5:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            cmd_d       = {shift_q, mosi_s};
                            cmd_valid_d = 1'b1;
                            sample_d    = sel_sample;
                            state_d     = S_NULL;
                        end
                    end
                end
                S_NULL: begin
                    if (dclk_fall) begin
                        miso_d     = 1'b0;
                        data_cnt_d = 4'd11;
                        state_d    = S_DATA;
                    end
                end
                S_DATA: begin
                    if (dclk_fall) begin
                        miso_d = sample_q[data_cnt_q];
                        if (data_cnt_q == 4'd0) state_d = S_TAIL;
                        else data_cnt_d = data_cnt_q - 4'd1;
                    end
                end
                S_TAIL: begin
                    if (dclk_fall) miso_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cs_sync_q   <= '1;
            dclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            dclk_prev_q <= 1'b0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_cnt_q  <= '0;
            miso_q      <= 1'b0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            sample_q    <= '0;
            eof_q       <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            dclk_sync_q <= dclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_prev_q   <= cs_prev_d;
            dclk_prev_q <= dclk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_cnt_q  <= data_cnt_d;
            miso_q      <= miso_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            sample_q    <= sample_d;
            eof_q       <= eof_d;
            abort_q     <= abort_d;
        end
    end

    assign miso_o      = miso_q;
    assign cmd_o       = cmd_q;
    assign cmd_valid_o = cmd_valid_q;
    assign sample_o    = sample_q;
    assign eof_o       = eof_q;
    assign abort_o     = abort_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: plays the initiator side of the SPI link
// and checks command decode, returned sample, frame-close pulses and reset.
module tb_spi_adc_responder;

    localparam int HALF = 60;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cs_i = 1'b1;
    logic        dclk_i = 1'b0;
    logic        mosi_i = 1'b0;
    logic [95:0] samples_i = '0;
    logic        miso_o;
    logic [7:0]  cmd_o;
    logic        cmd_valid_o;
    logic [11:0] sample_o;
    logic        eof_o;
    logic        abort_o;
    logic [2:0]  dbg_state_o;

    int tests_run = 0;
    int tests_failed = 0;

    int          n_valid = 0;
    int          n_eof = 0;
    int          n_abort = 0;
    logic [7:0]  cmd_seen = '0;
    logic [11:0] sample_seen = '0;

    spi_adc_responder #(.SYNC_STAGES(2)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cs_i        (cs_i),
        .dclk_i      (dclk_i),
        .mosi_i      (mosi_i),
        .samples_i   (samples_i),
        .miso_o      (miso_o),
        .cmd_o       (cmd_o),
        .cmd_valid_o (cmd_valid_o),
        .sample_o    (sample_o),
        .eof_o       (eof_o),
        .abort_o     (abort_o),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    // Pulse monitor: counts one-cycle pulses and captures the decoded command.
    always @(negedge clk_i) begin
        if (cmd_valid_o) begin
            n_valid     <= n_valid + 1;
            cmd_seen    <= cmd_o;
            sample_seen <= sample_o;
        end
        if (eof_o) n_eof <= n_eof + 1;
        if (abort_o) n_abort <= n_abort + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic set_sample(input int ch, input logic [11:0] val);
        samples_i[ch*12 +: 12] = val;
    endtask

    // Initiator: ncyc dclk cycles, lead zero bits, then cmd MSB first. MISO is
    // read just before each rising edge; close=1 ends with cs high.
    task automatic run_frame(input logic [7:0] cmd, input int lead, input int ncyc,
                             input bit close, output logic [11:0] rd, output logic null_bit);
        rd = '0;
        null_bit = 1'b1;
        cs_i = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            if (k > lead && k <= lead + 8) mosi_i = cmd[7-(k-lead-1)];
            else mosi_i = 1'b0;
            wait_clk(HALF);
            if (k == lead + 9) null_bit = miso_o;
            if (k >= lead + 10 && k <= lead + 21) rd = {rd[10:0], miso_o};
            dclk_i = 1'b1;
            wait_clk(HALF);
            dclk_i = 1'b0;
        end
        if (close) begin
            wait_clk(HALF);
            cs_i = 1'b1;
            wait_clk(30);
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        wait_clk(5);
        tests_run++; if (miso_o !== 1'b0) begin tests_failed++; $display("FAIL reset_miso: got %b want 0", miso_o); end
        tests_run++; if (cmd_o !== 8'h00) begin tests_failed++; $display("FAIL reset_cmd: got %h want 00", cmd_o); end
        tests_run++; if (cmd_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid_o); end
        tests_run++; if (sample_o !== 12'h000) begin tests_failed++; $display("FAIL reset_sample: got %h want 000", sample_o); end
        tests_run++; if (eof_o !== 1'b0 || abort_o !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses: got eof=%b abort=%b want 0 0", eof_o, abort_o); end
        tests_run++; if (dbg_state_o !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", dbg_state_o); end
        rst_i = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_normal_frame(input int lead, input string name);
        logic [11:0] rd;
        logic        nb;
        int          v0, e0, a0;
        set_sample(1, 12'hABC);
        v0 = n_valid; e0 = n_eof; a0 = n_abort;
        run_frame(8'h97, lead, 24 + lead, 1'b1, rd, nb);
        tests_run++; if (n_valid - v0 != 1) begin tests_failed++; $display("FAIL %s_valid_count: got %0d want 1", name, n_valid - v0); end
        tests_run++; if (cmd_seen !== 8'h97) begin tests_failed++; $display("FAIL %s_cmd: got %h want 97", name, cmd_seen); end
        tests_run++; if (sample_seen !== 12'hABC) begin tests_failed++; $display("FAIL %s_sample: got %h want abc", name, sample_seen); end
        tests_run++; if (nb !== 1'b0) begin tests_failed++; $display("FAIL %s_null_bit: got %b want 0", name, nb); end
        tests_run++; if (rd !== 12'hABC) begin tests_failed++; $display("FAIL %s_read: got %h want abc", name, rd); end
        tests_run++; if (n_eof - e0 != 1 || n_abort - a0 != 0) begin tests_failed++; $display("FAIL %s_close: got eof=%0d abort=%0d want 1 0", name, n_eof - e0, n_abort - a0); end
    endtask

    task automatic test_channel_sweep;
        logic [11:0] rd;
        logic        nb;
        logic [7:0]  cmd;
        for (int n = 0; n < 8; n++) set_sample(n, 12'h100 + 12'(n));
        for (int n = 0; n < 8; n++) begin
            cmd = {1'b1, 3'(n), 4'b0111};
            run_frame(cmd, 0, 24, 1'b1, rd, nb);
            tests_run++; if (rd !== 12'h100 + 12'(n) || cmd_seen !== cmd) begin tests_failed++; $display("FAIL sweep_ch%0d: got data=%h cmd=%h want data=%h cmd=%h", n, rd, cmd_seen, 12'h100 + 12'(n), cmd); end
        end
    endtask

    task automatic test_late_sample_change;
        logic [11:0] rd;
        logic        nb;
        logic        got;
        got = 1'b0;
        set_sample(2, 12'h5A5);
        fork
            run_frame(8'hA7, 0, 24, 1'b1, rd, nb);
            begin
                for (int i = 0; i < 4000 && !got; i++) begin
                    @(negedge clk_i);
                    if (cmd_valid_o) got = 1'b1;
                end
                if (got) begin
                    wait_clk(2);
                    set_sample(2, 12'hFFF);
                end
            end
        join
        tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL late_cmd_valid_timeout: got %b want 1", got); end
        tests_run++; if (rd !== 12'h5A5) begin tests_failed++; $display("FAIL late_read: got %h want 5a5", rd); end
    endtask

    task automatic test_abort;
        logic [11:0] rd;
        logic        nb;
        logic        seen;
        int          e0, a0;
        seen = 1'b0;
        set_sample(1, 12'h0FF);
        e0 = n_eof; a0 = n_abort;
        run_frame(8'h97, 0, 14, 1'b0, rd, nb);
        wait_clk(10);
        // After falling edge 14 the responder drives D6 of 0x0FF, which is 1.
        tests_run++; if (miso_o !== 1'b1) begin tests_failed++; $display("FAIL abort_pre_miso: got %b want 1", miso_o); end
        cs_i = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_i);
            if (abort_o) seen = 1'b1;
        end
        tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL abort_pulse_timeout: got %b want 1", seen); end
        tests_run++; if (miso_o !== 1'b0) begin tests_failed++; $display("FAIL abort_miso: got %b want 0", miso_o); end
        wait_clk(30);
        tests_run++; if (n_abort - a0 != 1 || n_eof - e0 != 0) begin tests_failed++; $display("FAIL abort_count: got abort=%0d eof=%0d want 1 0", n_abort - a0, n_eof - e0); end
        test_normal_frame(0, "after_abort");
    endtask

    task automatic test_reset_mid_data;
        logic [11:0] rd;
        logic        nb;
        int          e0, a0;
        set_sample(1, 12'hABC);
        run_frame(8'h97, 0, 14, 1'b0, rd, nb);
        wait_clk(10);
        e0 = n_eof; a0 = n_abort;
        rst_i = 1'b0;
        #1;
        tests_run++; if (miso_o !== 1'b0 || cmd_o !== 8'h00 || sample_o !== 12'h000) begin tests_failed++; $display("FAIL rst_mid_outputs: got miso=%b cmd=%h sample=%h want 0 00 000", miso_o, cmd_o, sample_o); end
        tests_run++; if (dbg_state_o !== 3'd0) begin tests_failed++; $display("FAIL rst_mid_state: got %0d want 0", dbg_state_o); end
        cs_i = 1'b1;
        wait_clk(5);
        rst_i = 1'b1;
        wait_clk(20);
        tests_run++; if (n_eof - e0 != 0 || n_abort - a0 != 0) begin tests_failed++; $display("FAIL rst_mid_pulses: got eof=%0d abort=%0d want 0 0", n_eof - e0, n_abort - a0); end
        test_normal_frame(0, "after_reset");
    endtask

    initial begin
        test_reset;
        test_normal_frame(0, "normal");
        test_normal_frame(3, "leading_zeros");
        test_channel_sweep;
        test_late_sample_change;
        test_abort;
        test_reset_mid_data;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
